// File: rtl/base_r_encoder_64b66b_if.sv
// MII-side word input and encoded-block output of the BASE-R 64b/66b transmit encoder.
// The MII frame generator holds the master end; the encoder holds the slave end.
interface base_r_encoder_64b66b_if #(
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     i_valid;
    logic [63:0]              i_mii_tx_d;
    logic [7:0]               i_mii_tx_c;
    logic [65:0]              o_tx_block;
    logic                     o_valid;
    logic [ERR_CNT_WIDTH-1:0] o_err_cnt;

    modport master (
        output i_valid, i_mii_tx_d, i_mii_tx_c,
        input  o_tx_block, o_valid, o_err_cnt
    );

    modport slave (
        input  i_valid, i_mii_tx_d, i_mii_tx_c,
        output o_tx_block, o_valid, o_err_cnt
    );
endinterface

// File: rtl/base_r_encoder_64b66b.sv
// BASE-R 64b/66b transmit encoder with TX state machine and saturating error-block counter.
// Optional payload scrambler (x^58+x^39+1) is enabled by defining BASE_R_SCRAMBLER_EN.
//
// state   | meaning
// TX_INIT | after reset, no block classified yet
// TX_C    | last block was control (idle/error characters)
// TX_D    | inside a frame (after start or data)
// TX_T    | last block terminated a frame
// TX_E    | last block was replaced by an error block
module base_r_encoder_64b66b #(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    base_r_encoder_64b66b_if.slave  bus
);

    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;
    typedef enum logic [2:0] {CL_C, CL_S, CL_D, CL_T, CL_E} blk_class_e;

    localparam logic [7:0]  TYPE_C = 8'h1E;
    localparam logic [7:0]  TYPE_S = 8'h78;
    localparam logic [63:0] EBLOCK = {{8{7'h1E}}, TYPE_C};
    localparam logic [7:0]  T_TYPE [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                                          8'hCC, 8'hD2, 8'hE1, 8'hFF};

    tx_state_e              state_q, state_d;
    logic [65:0]            block_q, block_d;
    logic                   valid_q, valid_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    blk_class_e             blk_class;
    logic [2:0]             t_lane;
    logic [63:0]            payload;
    logic [63:0]            payload_out;

    // Classify the incoming word; t_lane is the lane carrying /T/ when the class is CL_T.
    always_comb begin
        logic ok;
        blk_class = CL_E;
        t_lane    = 3'd0;
        ok        = 1'b0;
        if (bus.i_mii_tx_c == 8'h00) begin
            blk_class = CL_D;
        end else if (bus.i_mii_tx_c == 8'h01 && bus.i_mii_tx_d[7:0] == 8'hFB) begin
            blk_class = CL_S;
        end else begin
            if (bus.i_mii_tx_c == 8'hFF) begin
                ok = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    if (bus.i_mii_tx_d[8*k +: 8] != 8'h07 && bus.i_mii_tx_d[8*k +: 8] != 8'hFE)
                        ok = 1'b0;
                end
                if (ok) blk_class = CL_C;
            end
            for (int n = 0; n < 8; n++) begin
                if (bus.i_mii_tx_c == 8'(8'hFF << n)) begin
                    ok = (bus.i_mii_tx_d[8*n +: 8] == 8'hFD);
                    for (int k = n + 1; k < 8; k++) begin
                        if (bus.i_mii_tx_d[8*k +: 8] != 8'h07) ok = 1'b0;
                    end
                    if (ok) begin
                        blk_class = CL_T;
                        t_lane    = 3'(n);
                    end
                end
            end
        end
    end

    always_comb begin
        payload = EBLOCK;
        case (blk_class)
            CL_C: begin
                payload = {56'd0, TYPE_C};
                for (int k = 0; k < 8; k++) begin
                    payload[8 + 7*k +: 7] = (bus.i_mii_tx_d[8*k +: 8] == 8'hFE) ? 7'h1E : 7'h00;
                end
            end
            CL_S: payload = {bus.i_mii_tx_d[63:8], TYPE_S};
            CL_D: payload = bus.i_mii_tx_d;
            CL_T: begin
                payload = {56'd0, T_TYPE[t_lane]};
                for (int k = 0; k < 7; k++) begin
                    if (k < int'(t_lane)) payload[8*k + 8 +: 8] = bus.i_mii_tx_d[8*k +: 8];
                end
            end
            default: payload = EBLOCK;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (bus.i_valid) begin
            case (state_q)
                TX_D: begin
                    case (blk_class)
                        CL_D:    state_d = TX_D;
                        CL_T:    state_d = TX_T;
                        default: state_d = TX_E;
                    endcase
                end
                TX_E: begin
                    case (blk_class)
                        CL_D, CL_S: state_d = TX_D;
                        CL_T:       state_d = TX_T;
                        CL_C:       state_d = TX_C;
                        default:    state_d = TX_E;
                    endcase
                end
                default: begin
                    case (blk_class)
                        CL_C:    state_d = TX_C;
                        CL_S:    state_d = TX_D;
                        default: state_d = TX_E;
                    endcase
                end
            endcase
        end
    end

    wire to_err = (state_d == TX_E);
    wire [63:0] payload_sel = to_err ? EBLOCK : payload;
    wire [1:0]  header_sel  = (!to_err && blk_class == CL_D) ? 2'b01 : 2'b10;

`ifdef BASE_R_SCRAMBLER_EN
    logic [57:0] scr_q, scr_d;

    // Self-synchronous: each output bit feeds back into the shift register, payload bit 0 first.
    always_comb begin
        logic [57:0] s;
        logic        b;
        s           = scr_q;
        payload_out = '0;
        for (int i = 0; i < 64; i++) begin
            b              = payload_sel[i] ^ s[38] ^ s[57];
            payload_out[i] = b;
            s              = {s[56:0], b};
        end
        scr_d = bus.i_valid ? s : scr_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) scr_q <= '1;
        else          scr_q <= scr_d;
    end
`else
    assign payload_out = payload_sel;
`endif

    always_comb begin
        block_d   = block_q;
        valid_d   = 1'b0;
        err_cnt_d = err_cnt_q;
        if (bus.i_valid) begin
            block_d = {payload_out, header_sel};
            valid_d = 1'b1;
            if (to_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= TX_INIT;
            block_q   <= '0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            valid_q   <= valid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_tx_block = block_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_base_r_encoder_64b66b.sv
// Directed-vector bench for base_r_encoder_64b66b; with BASE_R_SCRAMBLER_EN the
// observed blocks are descrambled by a loopback model before comparison.
module tb_base_r_encoder_64b66b;

    localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
    localparam logic [65:0] IDLE_B   = 66'h7A;
    localparam logic [63:0] IDLEE_D  = 64'h07070707070707FE;
    localparam logic [65:0] IDLEE_B  = {64'h0000000000001E1E, 2'b10};
    localparam logic [63:0] START_D  = 64'hD5555555555555FB;
    localparam logic [65:0] START_B  = {56'hD5555555555555, 8'h78, 2'b10};
    localparam logic [63:0] DATA_D   = 64'h0123456789ABCDEF;
    localparam logic [65:0] DATA_B   = {64'h0123456789ABCDEF, 2'b01};
    localparam logic [63:0] DATA2_D  = 64'hFEDCBA9876543210;
    localparam logic [65:0] DATA2_B  = {64'hFEDCBA9876543210, 2'b01};
    localparam logic [63:0] T5_D     = 64'h0707FD5544332211;
    localparam logic [65:0] T5_B     = {64'h00005544332211D2, 2'b10};
    localparam logic [63:0] T7_D     = 64'hFD77665544332211;
    localparam logic [65:0] T7_B     = {64'h77665544332211FF, 2'b10};
    localparam logic [63:0] T0_D     = 64'h07070707070707FD;
    localparam logic [65:0] T0_B     = {64'h0000000000000087, 2'b10};
    localparam logic [65:0] EBLK_B   = {{8{7'h1E}}, 8'h1E, 2'b10};

    logic clk;
    logic i_rst_n;
    int   n_chk;
    int   n_fail;
    logic [65:0] rx_blk;
    logic [65:0] raw_hold;
    logic [57:0] dscr_q;

    base_r_encoder_64b66b_if #(.ERR_CNT_WIDTH(16)) bus ();

    base_r_encoder_64b66b #(.ERR_CNT_WIDTH(16)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 time unit after the capturing edge.
    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c);
        logic [57:0] s;
        logic [65:0] b;
        @(negedge clk);
        bus.i_valid    = v;
        bus.i_mii_tx_d = d;
        bus.i_mii_tx_c = c;
        @(posedge clk);
        #1;
        b = bus.o_tx_block;
`ifdef BASE_R_SCRAMBLER_EN
        if (bus.o_valid) begin
            s = dscr_q;
            for (int i = 0; i < 64; i++) begin
                b[i + 2] = bus.o_tx_block[i + 2] ^ s[38] ^ s[57];
                s        = {s[56:0], bus.o_tx_block[i + 2]};
            end
            dscr_q = s;
            rx_blk = b;
        end
`else
        s      = dscr_q;
        dscr_q = s;
        rx_blk = b;
`endif
    endtask

    task automatic send(input string tag, input logic [63:0] d, input logic [7:0] c,
                        input logic [65:0] exp_blk, input logic [15:0] exp_err);
        drive(1'b1, d, c);
        chk({tag, "_blk"}, rx_blk, exp_blk);
        chk({tag, "_err"}, {50'd0, bus.o_err_cnt}, {50'd0, exp_err});
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rx_blk         = '0;
        dscr_q         = '1;
        i_rst_n        = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_mii_tx_d = '0;
        bus.i_mii_tx_c = '0;
        repeat (2) @(negedge clk);
        chk("rst_blk",   bus.o_tx_block, 66'd0);
        chk("rst_valid", {65'd0, bus.o_valid}, 66'd0);
        chk("rst_err",   {50'd0, bus.o_err_cnt}, 66'd0);
        i_rst_n = 1'b1;

        send("idle", IDLE_D, 8'hFF, IDLE_B, 16'd0);
        chk("idle_valid", {65'd0, bus.o_valid}, 66'd1);
        send("start", START_D, 8'h01, START_B, 16'd0);
        send("data", DATA_D, 8'h00, DATA_B, 16'd0);

        raw_hold = bus.o_tx_block;
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, IDLE_D, 8'hFF);
            chk("gap_valid", {65'd0, bus.o_valid}, 66'd0);
            chk("gap_hold",  bus.o_tx_block, raw_hold);
        end
        send("data_after_gap", DATA2_D, 8'h00, DATA2_B, 16'd0);
        chk("data_after_gap_valid", {65'd0, bus.o_valid}, 66'd1);

        send("term5", T5_D, 8'hE0, T5_B, 16'd0);
        send("idle_err_char", IDLEE_D, 8'hFF, IDLEE_B, 16'd0);
        send("c_then_d", DATA_D, 8'h00, EBLK_B, 16'd1);
        send("e_then_s", START_D, 8'h01, START_B, 16'd1);
        send("term7", T7_D, 8'h80, T7_B, 16'd1);
        send("t_then_s", START_D, 8'h01, START_B, 16'd1);
        send("term0", T0_D, 8'hFF, T0_B, 16'd1);

        // Illegal control pattern drives every block to an error block.
        for (int i = 0; i < 65532; i++) drive(1'b1, DATA_D, 8'h55);
        chk("sat_m2", {50'd0, bus.o_err_cnt}, {50'd0, 16'hFFFD});
        send("sat_m1", DATA_D, 8'h55, EBLK_B, 16'hFFFE);
        send("sat_hit", DATA_D, 8'h55, EBLK_B, 16'hFFFF);
        for (int i = 0; i < 4; i++) drive(1'b1, DATA_D, 8'h55);
        chk("sat_hold", {50'd0, bus.o_err_cnt}, {50'd0, 16'hFFFF});
        chk("sat_blk", rx_blk, EBLK_B);

        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_blk",   bus.o_tx_block, 66'd0);
        chk("midrst_valid", {65'd0, bus.o_valid}, 66'd0);
        chk("midrst_err",   {50'd0, bus.o_err_cnt}, 66'd0);
        bus.i_valid = 1'b0;
        dscr_q      = '1;
        @(negedge clk);
        i_rst_n = 1'b1;

        send("init_then_s", START_D, 8'h01, START_B, 16'd0);
        send("init_data", DATA_D, 8'h00, DATA_B, 16'd0);
        send("init_term5", T5_D, 8'hE0, T5_B, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
